// File: rtl/ov7670_pkg.sv
// ============================================================================
// ov7670_pkg : shared state encoding, pattern codes, bar table, timing defaults
// Rev 1.0
// ============================================================================
`default_nettype none

package ov7670_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_VSYNC  = 3'd1;
  localparam state_t ST_VBACK  = 3'd2;
  localparam state_t ST_ACTIVE = 3'd3;
  localparam state_t ST_HBLANK = 3'd4;
  localparam state_t ST_VFRONT = 3'd5;

  localparam logic [1:0] PAT_BARS     = 2'd0;
  localparam logic [1:0] PAT_GRADIENT = 2'd1;
  localparam logic [1:0] PAT_CHECKER  = 2'd2;
  localparam logic [1:0] PAT_SOLID    = 2'd3;

  localparam int DEF_H_WIDTH    = 320;
  localparam int DEF_V_WIDTH    = 240;
  localparam int DEF_H_BLANK    = 144;
  localparam int DEF_VS_LINES   = 3;
  localparam int DEF_VB_LINES   = 17;
  localparam int DEF_VF_LINES   = 10;
  localparam int DEF_DATA_WIDTH = 8;

  // RGB565 colour bars: white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ov7670_pattern_gen.sv
// ============================================================================
// ov7670_pattern_gen : combinational (x, y, frame, pattern) -> RGB565 pixel
// Rev 1.0
// ============================================================================
`default_nettype none

module ov7670_pattern_gen
  import ov7670_pkg::*;
#(
  parameter int H_WIDTH = DEF_H_WIDTH
) (
  input  logic [15:0] x_i,
  input  logic [7:2]  y_i,
  input  logic [4:0]  frame_i,
  input  logic [1:0]  pattern_i,
  output logic [15:0] pixel_o
);

  localparam int BAR_W = (H_WIDTH >= 8) ? (H_WIDTH / 8) : 1;

  logic [15:0] bar_idx_w;
  logic [2:0]  bar_sel_w;

  // Clamp so any remainder columns past the eighth bar stay in the last bar
  assign bar_idx_w = x_i / 16'(BAR_W);
  assign bar_sel_w = (bar_idx_w > 16'd7) ? 3'd7 : bar_idx_w[2:0];

  always_comb begin
    pixel_o = 16'h0000;
    case (pattern_i)
      PAT_BARS:     pixel_o = bar_colour(bar_sel_w);
      PAT_GRADIENT: pixel_o = {x_i[7:3], y_i[7:2], frame_i};
      PAT_CHECKER:  pixel_o = (x_i[4] ^ y_i[4]) ? 16'hFFFF : 16'h0000;
      default:      pixel_o = bar_colour(frame_i[2:0]);
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ov7670_tx_emulator.sv
// ============================================================================
// ov7670_tx_emulator : OV7670-style VS/HREF/PCLK/RGB565 test-pattern source
// Rev 1.0
// ============================================================================
`default_nettype none

module ov7670_tx_emulator
  import ov7670_pkg::*;
#(
  parameter int H_WIDTH    = DEF_H_WIDTH,
  parameter int V_WIDTH    = DEF_V_WIDTH,
  parameter int H_BLANK    = DEF_H_BLANK,
  parameter int VS_LINES   = DEF_VS_LINES,
  parameter int VB_LINES   = DEF_VB_LINES,
  parameter int VF_LINES   = DEF_VF_LINES,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [1:0]            i_pattern,
  output logic                  o_PCLK,
  output logic                  o_VS,
  output logic                  o_HS,
  output logic [DATA_WIDTH-1:0] o_DATA,
  output logic                  o_frame_done,
  output logic                  o_busy
);

  localparam int LINE_LEN = 2 * H_WIDTH + H_BLANK;
  localparam int ACT_LEN  = 2 * H_WIDTH;
  localparam int V_MAX_A  = (V_WIDTH > VS_LINES) ? V_WIDTH : VS_LINES;
  localparam int V_MAX_B  = (VB_LINES > VF_LINES) ? VB_LINES : VF_LINES;
  localparam int V_MAX    = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
  localparam int HC_W     = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int VC_W     = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  localparam logic [HC_W-1:0] HC_LAST     = HC_W'(LINE_LEN - 1);
  localparam logic [HC_W-1:0] HC_ACT_LAST = HC_W'(ACT_LEN - 1);
  localparam logic [HC_W-1:0] HC_ONE      = HC_W'(1);
  localparam logic [VC_W-1:0] VC_ONE      = VC_W'(1);
  localparam logic [VC_W-1:0] VS_LAST     = VC_W'(VS_LINES - 1);
  localparam logic [VC_W-1:0] VB_LAST     = VC_W'(VB_LINES - 1);
  localparam logic [VC_W-1:0] VA_LAST     = VC_W'(V_WIDTH - 1);
  localparam logic [VC_W-1:0] VF_LAST     = VC_W'(VF_LINES - 1);

  state_t            state_q,      state_d;
  logic [HC_W-1:0]   hcnt_q,       hcnt_d;
  logic [VC_W-1:0]   vcnt_q,       vcnt_d;
  logic [1:0]        pattern_q,    pattern_d;
  logic [7:0]        frame_cnt_q,  frame_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              pclk_q;

  logic              tick_w;
  logic              line_end_w;
  logic [15:0]       pixel_w;
  logic [7:0]        byte_w;

  assign tick_w     = pclk_q;
  assign line_end_w = (hcnt_q == HC_LAST);

  // hcnt runs one full line time in every state; in ACTIVE it is the byte index
  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    pattern_d    = pattern_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    if (tick_w) begin
      hcnt_d = line_end_w ? '0 : hcnt_q + HC_ONE;
      case (state_q)
        ST_IDLE: begin
          hcnt_d = '0;
          if (i_enable) begin
            state_d   = ST_VSYNC;
            pattern_d = i_pattern;
            vcnt_d    = '0;
          end
        end
        ST_VSYNC: begin
          if (line_end_w) begin
            if (vcnt_q == VS_LAST) begin
              state_d = ST_VBACK;
              vcnt_d  = '0;
            end else begin
              vcnt_d = vcnt_q + VC_ONE;
            end
          end
        end
        ST_VBACK: begin
          if (line_end_w) begin
            if (vcnt_q == VB_LAST) begin
              state_d = ST_ACTIVE;
              vcnt_d  = '0;
            end else begin
              vcnt_d = vcnt_q + VC_ONE;
            end
          end
        end
        ST_ACTIVE: begin
          if (hcnt_q == HC_ACT_LAST) begin
            state_d = ST_HBLANK;
          end
        end
        ST_HBLANK: begin
          if (line_end_w) begin
            if (vcnt_q == VA_LAST) begin
              state_d = ST_VFRONT;
              vcnt_d  = '0;
            end else begin
              state_d = ST_ACTIVE;
              vcnt_d  = vcnt_q + VC_ONE;
            end
          end
        end
        ST_VFRONT: begin
          if (line_end_w) begin
            if (vcnt_q == VF_LAST) begin
              frame_done_d = 1'b1;
              frame_cnt_d  = frame_cnt_q + 8'd1;
              vcnt_d       = '0;
              if (i_enable) begin
                state_d   = ST_VSYNC;
                pattern_d = i_pattern;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              vcnt_d = vcnt_q + VC_ONE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          hcnt_d  = '0;
          vcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pclk_q       <= 1'b0;
      state_q      <= ST_IDLE;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      pattern_q    <= 2'd0;
      frame_cnt_q  <= 8'd0;
      frame_done_q <= 1'b0;
    end else begin
      pclk_q       <= ~pclk_q;
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      pattern_q    <= pattern_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  ov7670_pattern_gen #(
    .H_WIDTH (H_WIDTH)
  ) u_pattern_gen (
    .x_i       (16'(hcnt_q >> 1)),
    .y_i       (6'(vcnt_q >> 2)),
    .frame_i   (frame_cnt_q[4:0]),
    .pattern_i (pattern_q),
    .pixel_o   (pixel_w)
  );

  // Even byte index carries the high half of the RGB565 word
  assign byte_w = hcnt_q[0] ? pixel_w[7:0] : pixel_w[15:8];

  assign o_PCLK       = pclk_q;
  assign o_VS         = (state_q == ST_VSYNC);
  assign o_HS         = (state_q == ST_ACTIVE);
  assign o_DATA       = (state_q == ST_ACTIVE) ? DATA_WIDTH'(byte_w) : '0;
  assign o_frame_done = frame_done_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ov7670_tx_emulator.sv
// ============================================================================
// tb_ov7670_tx_emulator : frame-level reference model checked at PCLK rise
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ov7670_tx_emulator;

  localparam int HW      = 8;
  localparam int VW      = 4;
  localparam int HB      = 4;
  localparam int VSL     = 1;
  localparam int VBL     = 1;
  localparam int VFL     = 1;
  localparam int LINE    = 2 * HW + HB;
  localparam int FRAME_T = LINE * (VSL + VBL + VW + VFL);

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_enable = 1'b0;
  logic [1:0] i_pattern = 2'd0;
  logic       o_PCLK, o_VS, o_HS, o_frame_done, o_busy;
  logic [7:0] o_DATA;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  ov7670_tx_emulator #(
    .H_WIDTH(HW), .V_WIDTH(VW), .H_BLANK(HB),
    .VS_LINES(VSL), .VB_LINES(VBL), .VF_LINES(VFL), .DATA_WIDTH(8)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_pattern(i_pattern),
    .o_PCLK(o_PCLK), .o_VS(o_VS), .o_HS(o_HS), .o_DATA(o_DATA),
    .o_frame_done(o_frame_done), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Expected {VS, HS, DATA} for PCLK period t of a frame (t=0 is first VS period)
  function automatic logic [9:0] model(input int pat, input int fc, input int t);
    int          line, col, y, x, bi;
    logic        vs, hs;
    logic [31:0] xv, yv, fv;
    logic [15:0] px;
    logic [7:0]  d;
    line = t / LINE;
    col  = t % LINE;
    y    = line - VSL - VBL;
    x    = col / 2;
    vs   = (line < VSL);
    hs   = (y >= 0) && (y < VW) && (col < 2 * HW);
    xv   = x;
    yv   = y;
    fv   = fc;
    bi   = x / (HW / 8);
    if (bi > 7) bi = 7;
    case (pat)
      0:       px = bars[bi];
      1:       px = {xv[7:3], yv[7:2], fv[4:0]};
      2:       px = (xv[4] ^ yv[4]) ? 16'hFFFF : 16'h0000;
      default: px = bars[fc % 8];
    endcase
    d = 8'h00;
    if (hs) d = (col % 2 == 0) ? px[15:8] : px[7:0];
    return {vs, hs, d};
  endfunction

  task automatic step();
    @(negedge i_clk);
    if (o_frame_done === 1'b1) done_seen++;
  endtask

  task automatic next_tick();
    int n;
    n = 0;
    step();
    while (o_PCLK !== 1'b1 && n < 4) begin
      step();
      n++;
    end
  endtask

  task automatic check_frame(input int pat, input int fc, input int new_pat, input bit drop_en);
    int         d0, n, hs_pre;
    logic [9:0] obs, exp;
    d0 = done_seen;
    n = 0;
    hs_pre = 0;
    next_tick();
    while (o_VS !== 1'b1 && n < 2000) begin
      if (o_HS !== 1'b0) hs_pre++;
      next_tick();
      n++;
    end
    checks++;
    assert (o_VS === 1'b1) else begin
      errors++;
      $error("FAIL vs_start observed %b expected 1", o_VS);
    end
    checks++;
    assert (hs_pre === 0) else begin
      errors++;
      $error("FAIL hs_before_vs observed %0d expected 0", hs_pre);
    end
    for (int t = 0; t < FRAME_T; t++) begin
      if (t > 0) next_tick();
      if (t == 50) i_pattern = 2'(new_pat);
      if (drop_en && t == 65) i_enable = 1'b0;
      obs = {o_VS, o_HS, o_DATA};
      exp = model(pat, fc, t);
      checks++;
      assert (obs === exp) else begin
        errors++;
        $error("FAIL frame_p%0d_t%0d observed %h expected %h", pat, t, obs, exp);
      end
    end
    step();
    checks++;
    assert ({o_frame_done, o_PCLK} === 2'b10) else begin
      errors++;
      $error("FAIL done_at_end observed %b expected 10", {o_frame_done, o_PCLK});
    end
    checks++;
    assert (done_seen - d0 === 1) else begin
      errors++;
      $error("FAIL done_count observed %0d expected 1", done_seen - d0);
    end
  endtask

  initial begin
    int fc, cur, np, n, d0;

    repeat (3) step();
    checks++;
    assert ({o_PCLK, o_VS, o_HS, o_DATA, o_frame_done, o_busy} === 13'b0) else begin
      errors++;
      $error("FAIL reset_outputs observed %b expected 0", {o_PCLK, o_VS, o_HS, o_DATA, o_frame_done, o_busy});
    end
    step();
    checks++;
    assert (o_PCLK === 1'b0) else begin
      errors++;
      $error("FAIL reset_pclk observed %b expected 0", o_PCLK);
    end

    i_reset = 1'b0;
    repeat (40) step();
    checks++;
    assert ({o_busy, o_VS, o_HS} === 3'b000) else begin
      errors++;
      $error("FAIL idle_no_enable observed %b expected 000", {o_busy, o_VS, o_HS});
    end

    // Solid colour over nine frames; the mid-frame switch on the last one only lands next frame
    fc = 0;
    i_pattern = 2'd3;
    i_enable  = 1'b1;
    for (int f = 0; f < 9; f++) begin
      np = (f == 8) ? 0 : 3;
      check_frame(3, fc, np, 1'b0);
      fc = (fc + 1) % 256;
    end

    cur = 0;
    for (int f = 0; f < 5; f++) begin
      np = int'($urandom_range(0, 3));
      check_frame(cur, fc, np, 1'b0);
      fc  = (fc + 1) % 256;
      cur = np;
    end

    check_frame(cur, fc, cur, 1'b1);
    fc = (fc + 1) % 256;
    repeat (30) next_tick();
    checks++;
    assert ({o_busy, o_VS, o_HS, o_DATA} === 11'b0) else begin
      errors++;
      $error("FAIL idle_after_drop observed %b expected 0", {o_busy, o_VS, o_HS, o_DATA});
    end

    cur = int'($urandom_range(0, 3));
    i_pattern = 2'(cur);
    i_enable  = 1'b1;
    check_frame(cur, fc, cur, 1'b0);
    fc = (fc + 1) % 256;

    // Abort a frame from inside an active line
    n = 0;
    next_tick();
    while (o_HS !== 1'b1 && n < 2000) begin
      next_tick();
      n++;
    end
    repeat (5) next_tick();
    checks++;
    assert (o_HS === 1'b1) else begin
      errors++;
      $error("FAIL in_active observed %b expected 1", o_HS);
    end
    i_reset = 1'b1;
    #1;
    checks++;
    assert ({o_PCLK, o_VS, o_HS, o_DATA, o_frame_done, o_busy} === 13'b0) else begin
      errors++;
      $error("FAIL async_reset observed %b expected 0", {o_PCLK, o_VS, o_HS, o_DATA, o_frame_done, o_busy});
    end
    d0 = done_seen;
    repeat (10) step();
    checks++;
    assert (done_seen - d0 === 0) else begin
      errors++;
      $error("FAIL done_on_abort observed %0d expected 0", done_seen - d0);
    end
    i_reset = 1'b0;
    cur = int'($urandom_range(0, 3));
    i_pattern = 2'(cur);
    check_frame(cur, 0, cur, 1'b0);

    i_enable = 1'b0;
    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
